ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Multi-cycle control sequencer for the 9-bit miniMips core. It walks each instruction through fetch, decode, execute, memory and write-back. It owns the program counter and the instruction register, and it gates the decoder's register-file and data-memory enables so that each takes effect in exactly one cycle. It sits between the instruction memory, the instruction decoder, the ALU branch outputs and the data memory, and it replaces free-running single-cycle operation.

## Interface
Parameters:
- PC_W, default 8, program counter width in bits.
- HALT_INSTR, default 9'h1FF, instruction encoding that stops execution.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins execution at PC 0; ignored while busy.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  PC_W  fetch address; always equals pc.
- instr_ack  in  1  fetch complete; instr_data is valid in the same cycle.
- instr_data  in  9  fetched instruction.
- ir  out  9  latched instruction; drives the decoder.
- dec_write_en  in  1  decoder register-write request.
- dec_mem_read  in  1  decoder load request.
- dec_mem_write  in  1  decoder store request.
- branch_taken  in  1  ALU branch decision, valid in EXEC.
- branch_target  in  PC_W  ALU branch target, valid in EXEC.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write qualifier; meaningful only while mem_req is high.
- mem_ack  in  1  data memory complete.
- rf_we  out  1  register-file write strobe.
- pc  out  PC_W  current program counter.
- busy  out  1  high in every state except IDLE and HALT.
- done  out  1  high in HALT.
- perf_cycles  out  16  cycle counter.
- perf_retired  out  16  retired-instruction counter.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start -> FETCH, pc <= 0.
- FETCH: instr_req = 1.
  - With instr_ack: ir <= instr_data, go to DECODE.
  - Without instr_ack: stay in FETCH.
- DECODE: one cycle for the decoder to settle.
  - ir == HALT_INSTR -> HALT.
  - Otherwise -> EXEC.
- EXEC: capture branch_taken into br_q and branch_target into tgt_q.
  - dec_mem_read or dec_mem_write -> MEM.
  - Otherwise -> WB.
- MEM: mem_req = 1 and mem_we = dec_mem_write.
  - Hold both until mem_ack, then go to WB.
  - If dec_mem_read and dec_mem_write are both high, the access is treated as a write.
- WB:
  - rf_we = dec_write_en for exactly this cycle.
  - pc <= br_q ? tgt_q : pc + 1. The pc + 1 wraps modulo 2^PC_W, so 0xFF goes to 0x00 when PC_W = 8.
  - Increment perf_retired, then go to FETCH.
- HALT: done = 1 and pc holds. start -> FETCH with pc <= 0.
- Acknowledge handling:
  - instr_ack outside FETCH is ignored.
  - mem_ack outside MEM is ignored.
  - An ack in the first cycle of its state is legal; that state then lasts one cycle.
- No timeout: the sequencer waits indefinitely for an acknowledge.

## Timing
- Reset: state = IDLE.
  - pc, ir, br_q, tgt_q = 0.
  - instr_req, mem_req, mem_we, rf_we, busy, done = 0.
  - perf_cycles, perf_retired = 0.
- Reset asserted mid-operation overrides everything. An outstanding request drops in the cycle after the reset edge and no write strobe is issued.
- instr_req, mem_req, mem_we, rf_we, busy and done are decoded from the registered state only, with no input-to-output combinational path. The one exception is mem_we, which follows dec_mem_write and is therefore combinational from ir through the decoder.
- Latency with zero-wait acknowledges:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each wait cycle adds one.
- The pc update and the rf_we strobe share the same WB cycle. The new instr_addr is presented on the first FETCH cycle that follows.
- start arriving on the same edge as reset: reset wins.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - perf_cycles increments every cycle while busy, saturating at 0xFFFF.
  - perf_retired increments once per WB, saturating at 0xFFFF.
  - Both counters clear on start.
- SEQ_PERF_CNT_EN undefined:
  - Both counters are omitted and both outputs are constant 0.
  - All other behaviour is identical.

## Test plan
- Reset, then start, then a non-memory add instruction with instr_ack immediate -> states FETCH, DECODE, EXEC, WB; rf_we high for exactly 1 cycle; pc 0 -> 1; perf_retired = 1.
- Store with mem_ack delayed 3 cycles -> mem_req and mem_we held high for 4 cycles; rf_we stays 0; total instruction latency 8 cycles.
- Branch at pc 5 with branch_taken = 1 and branch_target = 0x20 -> next instr_addr = 0x20. The same instruction with branch_taken = 0 -> next instr_addr = 6.
- pc = 0xFF with a non-branch instruction -> pc wraps to 0x00.
- Fetch of 9'h1FF -> HALT with done = 1 and busy = 0; a start pulse while busy has no effect; start in HALT restarts at pc 0.
- Reset asserted during MEM with mem_req high -> state IDLE, mem_req = 0, pc = 0 after one edge, and a later mem_ack produces no response.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit miniMips core.
// Define SEQ_PERF_CNT_EN to build the cycle and retired-instruction counters.
module ctrl_sequencer #(
    parameter int         PC_W       = 8,
    parameter logic [8:0] HALT_INSTR = 9'h1FF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_ack,
    input  logic [8:0]      instr_data,
    output logic [8:0]      ir,
    input  logic            dec_write_en,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic [15:0]     perf_cycles,
    output logic [15:0]     perf_retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      ir_q, ir_d;
    logic            br_q, br_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            we_q, we_d;
    logic            start_accept;

    assign start_accept = start && (state_q == S_IDLE || state_q == S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            br_q    <= 1'b0;
            tgt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            br_q    <= br_d;
            tgt_q   <= tgt_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH;
            S_FETCH:        if (instr_ack) state_d = S_DECODE;
            S_DECODE:       state_d = (ir_q == HALT_INSTR) ? S_HALT : S_EXEC;
            S_EXEC:         state_d = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
            S_MEM:          if (mem_ack) state_d = S_WB;
            S_WB:           state_d = S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    // The register-write request is sampled in EXEC so rf_we in WB comes from flops only.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        br_d  = br_q;
        tgt_d = tgt_q;
        we_d  = we_q;
        case (state_q)
            S_IDLE, S_HALT: if (start) pc_d = '0;
            S_FETCH:        if (instr_ack) ir_d = instr_data;
            S_EXEC: begin
                br_d  = branch_taken;
                tgt_d = branch_target;
                we_d  = dec_write_en;
            end
            S_WB:           pc_d = br_q ? tgt_q : pc_q + PC_W'(1);
            default: ;
        endcase
    end

    always_comb begin
        instr_req = (state_q == S_FETCH);
        mem_req   = (state_q == S_MEM);
        mem_we    = (state_q == S_MEM) && dec_mem_write;
        rf_we     = (state_q == S_WB) && we_q;
        busy      = (state_q != S_IDLE) && (state_q != S_HALT);
        done      = (state_q == S_HALT);
    end

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] ret_q, ret_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (start_accept) begin
            cyc_d = '0;
            ret_d = '0;
        end else begin
            if (busy && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
            if (state_q == S_WB && ret_q != 16'hFFFF) ret_d = ret_q + 16'd1;
        end
    end

    assign perf_cycles  = cyc_q;
    assign perf_retired = ret_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign perf_cycles  = '0;
    assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: random programs, random ack delays,
// a rule-level reference model and a decoupled monitor.
module tb_ctrl_sequencer;

    localparam int PC_W = 8;
    localparam int MAXN = 64;

    logic            clk = 1'b0;
    logic            reset, start;
    logic            instr_req, instr_ack;
    logic [PC_W-1:0] instr_addr;
    logic [8:0]      instr_data, ir;
    logic            dec_write_en, dec_mem_read, dec_mem_write, branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            mem_req, mem_we, mem_ack, rf_we, busy, done;
    logic [PC_W-1:0] pc;
    logic [15:0]     perf_cycles, perf_retired;

    always #5 clk = ~clk;

    ctrl_sequencer #(.PC_W(PC_W), .HALT_INSTR(9'h1FF)) dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
        .instr_data(instr_data), .ir(ir),
        .dec_write_en(dec_write_en), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .rf_we(rf_we), .pc(pc), .busy(busy), .done(done),
        .perf_cycles(perf_cycles), .perf_retired(perf_retired)
    );

    // Toy decoder: bit0 writes, bit3 loads, bit4 stores, bit5 branches.
    always_comb begin
        dec_write_en  = ir[0];
        dec_mem_read  = ir[3];
        dec_mem_write = ir[4];
        branch_taken  = ir[5];
        branch_target = ~{ir[8:6], ir[4:0]};
    end

    typedef struct {
        logic [7:0] addr;
        logic [8:0] instr;
        int         latency;
        int         rfPulses;
        int         memCycles;
        bit         memWrite;
    } expRec_t;

    expRec_t    expQ[$];
    expRec_t    cur;
    logic [8:0] traceInstr[MAXN];
    int         fwait[MAXN];
    int         mwait[MAXN];
    int         nChecks = 0;
    int         nErrors = 0;
    bit         monEn = 1'b0;
    bit         respEn = 1'b0;
    int         expBusyCycles, expRetired;
    logic [7:0] lastAddr;
    int         fk, fcnt, mcnt;
    bit         open, prevReq, prevDone;
    int         cyc, rfCnt, memCnt, weBad;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference model: walks the program by the architectural rules and
    // records what each instruction must look like from the outside.
    task automatic buildProgram(input int len, input bit injectBranches, input bit memAbort);
        logic [7:0] mpc;
        logic [8:0] ins;
        expRec_t    r;
        expQ.delete();
        expBusyCycles = 0;
        expRetired    = 0;
        mpc           = 8'd0;
        for (int k = 0; k < len; k++) begin
            ins = 9'($urandom);
            if (ins == 9'h1FF) ins = 9'h0FF;
            if (injectBranches && k == 1) ins = 9'h020;
            if (injectBranches && k == 2) ins = ins & 9'h1DF;
            if (injectBranches && k == 3) ins = 9'h1BF;
            if (memAbort && k == 0) ins = 9'h010;
            if (k == len - 1) ins = 9'h1FF;
            traceInstr[k] = ins;
            fwait[k] = int'($urandom_range(0, 3));
            mwait[k] = (memAbort && k == 0) ? 40 : int'($urandom_range(0, 3));
            r.addr  = mpc;
            r.instr = ins;
            if (ins == 9'h1FF) begin
                r.latency   = fwait[k] + 2;
                r.rfPulses  = 0;
                r.memCycles = 0;
                r.memWrite  = 1'b0;
            end else begin
                r.memWrite  = ins[4];
                r.memCycles = (ins[4] || ins[3]) ? mwait[k] + 1 : 0;
                r.rfPulses  = ins[0] ? 1 : 0;
                r.latency   = 4 + fwait[k] + r.memCycles;
                expRetired++;
                mpc = ins[5] ? ~{ins[8:6], ins[4:0]} : (mpc + 8'd1);
            end
            expBusyCycles += r.latency;
            lastAddr = r.addr;
            expQ.push_back(r);
        end
    endtask

    // Instruction memory: acks after the planned wait, noise otherwise.
    always @(negedge clk) begin
        if (!respEn) begin
            fk = 0;
            fcnt = 0;
            instr_ack = 1'b0;
            instr_data = 9'h000;
        end else if (instr_req) begin
            if (fk < MAXN && fcnt == fwait[fk]) begin
                instr_ack = 1'b1;
                instr_data = traceInstr[fk];
                fk++;
                fcnt = 0;
            end else begin
                instr_ack = 1'b0;
                instr_data = 9'($urandom);
                fcnt++;
            end
        end else begin
            instr_ack = 1'($urandom);
            instr_data = 9'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!respEn) begin
            mcnt = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (mcnt == mwait[(fk > 0) ? fk - 1 : 0]) begin
                mem_ack = 1'b1;
                mcnt = 0;
            end else begin
                mem_ack = 1'b0;
                mcnt++;
            end
        end else begin
            mem_ack = 1'($urandom);
            mcnt = 0;
        end
    end

    task automatic closeRec();
        checkOutput("ir_latched", 32'(ir), 32'(cur.instr));
        checkOutput("latency", 32'(cyc), 32'(cur.latency));
        checkOutput("rf_we_pulses", 32'(rfCnt), 32'(cur.rfPulses));
        checkOutput("mem_req_cycles", 32'(memCnt), 32'(cur.memCycles));
        checkOutput("mem_we_bad_cycles", 32'(weBad), 32'd0);
        open = 1'b0;
    endtask

    // Monitor: an instruction begins on an instr_req rising edge and ends at
    // the next one, or when done rises for the halt instruction.
    always @(negedge clk) begin
        if (!monEn) begin
            open = 1'b0;
            prevReq = 1'b0;
            prevDone = 1'b0;
        end else begin
            if (open && ((instr_req && !prevReq) || (done && !prevDone))) closeRec();
            if (instr_req && !prevReq) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL unexpected_fetch: actual addr=%0h required=no fetch", instr_addr);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("fetch_addr", 32'(instr_addr), 32'(cur.addr));
                    checkOutput("pc_at_fetch", 32'(pc), 32'(cur.addr));
                    open = 1'b1;
                    cyc = 0;
                    rfCnt = 0;
                    memCnt = 0;
                    weBad = 0;
                end
            end
            if (open) begin
                cyc++;
                if (rf_we) rfCnt++;
                if (mem_req) begin
                    memCnt++;
                    if (mem_we !== cur.memWrite) weBad++;
                end
            end
            prevReq = instr_req;
            prevDone = done;
        end
    end

    task automatic applyStimulus();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL %s_timeout: actual done=0 required done=1", tag);
        end
        @(negedge clk);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("done_in_halt", 32'(done), 32'd1);
        checkOutput("busy_in_halt", 32'(busy), 32'd0);
        checkOutput("pc_at_halt", 32'(pc), 32'(lastAddr));
`ifdef SEQ_PERF_CNT_EN
        checkOutput("perf_cycles", 32'(perf_cycles), 32'(expBusyCycles));
        checkOutput("perf_retired", 32'(perf_retired), 32'(expRetired));
`else
        checkOutput("perf_cycles", 32'(perf_cycles), 32'd0);
        checkOutput("perf_retired", 32'(perf_retired), 32'd0);
`endif
        repeat (3) @(negedge clk);
        checkOutput("pc_hold_halt", 32'(pc), 32'(lastAddr));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_instr_req", 32'(instr_req), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_ir", 32'(ir), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_perf_cycles", 32'(perf_cycles), 32'd0);
        checkOutput("rst_perf_retired", 32'(perf_retired), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Program 1: branch to 0xFF, wrap to 0x00, branch to 0x20, start while busy.
        buildProgram(30, 1'b1, 1'b0);
        monEn = 1'b1;
        respEn = 1'b1;
        applyStimulus();
        repeat (12) @(negedge clk);
        applyStimulus();
        waitDone("prog1");

        // Program 2: restart from HALT.
        respEn = 1'b0;
        repeat (2) @(negedge clk);
        buildProgram(20, 1'b0, 1'b0);
        respEn = 1'b1;
        applyStimulus();
        waitDone("prog2");

        // Program 3: reset while a store is waiting for mem_ack.
        respEn = 1'b0;
        repeat (2) @(negedge clk);
        buildProgram(5, 1'b0, 1'b1);
        respEn = 1'b1;
        applyStimulus();
        t = 0;
        while (!mem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("abort_mem_req", 32'(mem_req), 32'd1);
        checkOutput("abort_mem_we", 32'(mem_we), 32'd1);
        monEn = 1'b0;
        expQ.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_mem_req_drop", 32'(mem_req), 32'd0);
        checkOutput("abort_pc", 32'(pc), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_instr_req", 32'(instr_req), 32'd0);
        checkOutput("abort_ir", 32'(ir), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("post_abort_mem_req", 32'(mem_req), 32'd0);
            checkOutput("post_abort_rf_we", 32'(rf_we), 32'd0);
            checkOutput("post_abort_busy", 32'(busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
